// File: rtl/ysyx_rnu.sv
// Register rename stage: speculative/committed RAT and free bitmaps, one registered output slot.
// Latency 1 (fire -> out_valid next edge); in_ready drops while the output is stalled or no free preg.

package ysyx_pkg;
  parameter int YSYX_REG_SIZE = 32;
  parameter int YSYX_PHY_SIZE = 64;
  parameter int RLEN = $clog2(YSYX_REG_SIZE);
  parameter int PLEN = $clog2(YSYX_PHY_SIZE);
  parameter int XLEN = 32;

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      op;
    logic [RLEN-1:0] rd;
  } uop_t;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [PLEN-1:0] pr1;
    logic [PLEN-1:0] pr2;
    logic [PLEN-1:0] prd;
    logic [PLEN-1:0] prs;
  } prd_t;
endpackage

module ysyx_rnu
  import ysyx_pkg::*;
#(
  parameter int RNUM = YSYX_REG_SIZE,
  parameter int PNUM = YSYX_PHY_SIZE
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  uop_t            in_uop,
  input  logic [RLEN-1:0] in_rs1,
  input  logic [RLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output uop_t            out_uop,
  output prd_t            out_prd,
  input  logic            cm_valid,
  input  logic [RLEN-1:0] cm_rd,
  input  logic [PLEN-1:0] cm_prd,
  input  logic [PLEN-1:0] cm_prs,
  output logic [PLEN:0]   free_cnt
);

  localparam logic [PNUM-1:0] FREE_RST = {{(PNUM-RNUM){1'b1}}, {RNUM{1'b0}}};
  localparam logic [PLEN:0]   CNT_RST  = (PLEN+1)'(PNUM - RNUM);

  logic [PLEN-1:0] spec_rat   [RNUM];
  logic [PLEN-1:0] arch_rat   [RNUM];
  logic [PLEN-1:0] spec_rat_n [RNUM];
  logic [PLEN-1:0] arch_rat_n [RNUM];
  logic [PNUM-1:0] free, arch_free, free_n, arch_free_n;

  logic            need_alloc, free_any, fire, cm_en;
  logic [PLEN-1:0] alloc;

  function automatic logic [PLEN:0] popcnt(input logic [PNUM-1:0] v);
    logic [PLEN:0] c;
    c = '0;
    for (int i = 0; i < PNUM; i++) c = c + (PLEN+1)'(v[i]);
    return c;
  endfunction

  always_comb begin
    alloc = '0;
    for (int i = PNUM-1; i >= 0; i--) begin
      if (free[i]) alloc = PLEN'(i);
    end
  end

  assign need_alloc = (in_uop.rd != '0);
  assign free_any   = |free;
  assign in_ready   = !flush && (!out_valid || out_ready) && (!need_alloc || free_any);
  assign fire       = in_valid && in_ready;
  assign cm_en      = cm_valid && (cm_rd != '0);

  // Commit is folded in first so a flush restores the already-committed view.
  always_comb begin
    spec_rat_n  = spec_rat;
    arch_rat_n  = arch_rat;
    free_n      = free;
    arch_free_n = arch_free;
    if (cm_en) begin
      arch_rat_n[cm_rd]   = cm_prd;
      arch_free_n[cm_prd] = 1'b0;
      arch_free_n[cm_prs] = 1'b1;
      free_n[cm_prs]      = 1'b1;
    end
    if (flush) begin
      spec_rat_n = arch_rat_n;
      free_n     = arch_free_n;
    end else if (fire && need_alloc) begin
      spec_rat_n[in_uop.rd] = alloc;
      free_n[alloc]         = 1'b0;
    end
    spec_rat_n[0]  = '0;
    arch_rat_n[0]  = '0;
    free_n[0]      = 1'b0;
    arch_free_n[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RNUM; i++) begin
        spec_rat[i] <= PLEN'(i);
        arch_rat[i] <= PLEN'(i);
      end
      free      <= FREE_RST;
      arch_free <= FREE_RST;
      free_cnt  <= CNT_RST;
    end else begin
      spec_rat  <= spec_rat_n;
      arch_rat  <= arch_rat_n;
      free      <= free_n;
      arch_free <= arch_free_n;
      free_cnt  <= popcnt(free_n);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_uop   <= '0;
      out_prd   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_uop     <= in_uop;
      out_prd.op1 <= '0;
      out_prd.op2 <= '0;
      out_prd.pr1 <= spec_rat[in_rs1];
      out_prd.pr2 <= spec_rat[in_rs2];
      out_prd.prd <= need_alloc ? alloc : '0;
      out_prd.prs <= need_alloc ? spec_rat[in_uop.rd] : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_rnu.sv
// Bench for ysyx_rnu: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural rename model with an in-order commit queue.
module tb_ysyx_rnu;
  import ysyx_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  uop_t            in_uop = '0;
  logic [RLEN-1:0] in_rs1 = '0, in_rs2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  uop_t            out_uop;
  prd_t            out_prd;
  logic            cm_valid = 1'b0;
  logic [RLEN-1:0] cm_rd = '0;
  logic [PLEN-1:0] cm_prd = '0, cm_prs = '0;
  logic [PLEN:0]   free_cnt;

  ysyx_rnu dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop), .out_prd(out_prd),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_prd(cm_prd), .cm_prs(cm_prs),
    .free_cnt(free_cnt)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0, tot_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Behavioural model
  typedef struct { int rd; int prd; int prs; } ent_t;
  int   srat[32], arat[32];
  bit   sfree[64], afree[64];
  bit   m_ov;
  uop_t m_uop;
  int   m_pr1, m_pr2, m_prd, m_prs, m_fc;
  ent_t rob[$];

  function automatic int lowest_free();
    for (int i = 0; i < 64; i++) if (sfree[i]) return i;
    return -1;
  endfunction

  function automatic int count_free();
    int c = 0;
    for (int i = 0; i < 64; i++) c += sfree[i];
    return c;
  endfunction

  function automatic bit exp_ready();
    return !flush && (!m_ov || out_ready) && (in_uop.rd == 0 || lowest_free() >= 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin srat[i] = i; arat[i] = i; end
    for (int i = 0; i < 64; i++) begin sfree[i] = (i >= 32); afree[i] = (i >= 32); end
    m_ov = 0; m_uop = '0; m_pr1 = 0; m_pr2 = 0; m_prd = 0; m_prs = 0; m_fc = 32;
    rob.delete();
  endtask

  task automatic model_edge(input bit fire);
    int a, rd, p1, p2, ps;
    a  = lowest_free();
    rd = int'(in_uop.rd);
    p1 = srat[in_rs1];
    p2 = srat[in_rs2];
    ps = (rd != 0) ? srat[rd] : 0;
    if (cm_valid && cm_rd != 0) begin
      arat[cm_rd] = cm_prd; afree[cm_prd] = 0; afree[cm_prs] = 1; sfree[cm_prs] = 1;
    end
    if (flush) begin
      srat = arat; sfree = afree; m_ov = 0; rob.delete();
    end else if (fire) begin
      m_ov = 1; m_uop = in_uop; m_pr1 = p1; m_pr2 = p2; m_prs = ps;
      m_prd = (rd != 0) ? a : 0;
      if (rd != 0) begin
        srat[rd] = a; sfree[a] = 0;
        rob.push_back('{rd: rd, prd: a, prs: ps});
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    m_fc = count_free();
  endtask

  task automatic tick();
    bit f;
    f = in_valid && exp_ready();
    @(posedge clock);
    #1;
    model_edge(f);
  endtask

  task automatic do_reset();
    chk_en = 0;
    reset = 0; flush = 0; in_valid = 0; in_uop = '0; in_rs1 = '0; in_rs2 = '0;
    out_ready = 1; cm_valid = 0; cm_rd = '0; cm_prd = '0; cm_prs = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk_en = 1;
  endtask

  task automatic set_in(input bit v, input int rd, input int r1, input int r2);
    in_valid = v;
    in_uop.rd = RLEN'(rd);
    in_uop.pc = $urandom;
    in_uop.op = 8'($urandom);
    in_rs1 = RLEN'(r1);
    in_rs2 = RLEN'(r2);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("free_cnt", 64'(free_cnt), 64'(m_fc));
      if (m_ov) begin
        chk("pr1", 64'(out_prd.pr1), 64'(m_pr1));
        chk("pr2", 64'(out_prd.pr2), 64'(m_pr2));
        chk("prd", 64'(out_prd.prd), 64'(m_prd));
        chk("prs", 64'(out_prd.prs), 64'(m_prs));
        chk("op12", {out_prd.op1, out_prd.op2}, 64'd0);
        chk("uop", 64'(out_uop), 64'(m_uop));
      end
    end
  end

  initial begin
    ent_t e;
    logic [31:0] held_pc;

    // 1: reset state and first rename
    do_reset();
    chk("t1_fc_rst", 64'(free_cnt), 64'd32);
    chk("t1_ov_rst", 64'(out_valid), 64'd0);
    set_in(1, 5, 1, 2); tick();
    chk("t1_ov", 64'(out_valid), 64'd1);
    chk("t1_pr1", 64'(out_prd.pr1), 64'd1);
    chk("t1_pr2", 64'(out_prd.pr2), 64'd2);
    chk("t1_prs", 64'(out_prd.prs), 64'd5);
    chk("t1_prd", 64'(out_prd.prd), 64'd32);
    @(negedge clock);
    chk("t1_fc", 64'(free_cnt), 64'd31);

    // 2: back-to-back rd=rs1, then rd=0
    do_reset();
    set_in(1, 5, 5, 0); tick(); tick();
    chk("t2_pr1", 64'(out_prd.pr1), 64'd32);
    chk("t2_prs", 64'(out_prd.prs), 64'd32);
    chk("t2_prd", 64'(out_prd.prd), 64'd33);
    set_in(1, 0, 3, 0); tick();
    chk("t2_prd0", 64'(out_prd.prd), 64'd0);
    chk("t2_prs0", 64'(out_prd.prs), 64'd0);
    chk("t2_fc", 64'(free_cnt), 64'd30);

    // 3: exhaust free list, then commit frees p5
    do_reset();
    for (int i = 0; i < 32; i++) begin set_in(1, ((i + 4) % 31) + 1, 0, 0); tick(); end
    chk("t3_fc0", 64'(free_cnt), 64'd0);
    set_in(1, 7, 0, 0); #1;
    chk("t3_rdy_full", 64'(in_ready), 64'd0);
    set_in(1, 0, 0, 0); #1;
    chk("t3_rdy_x0", 64'(in_ready), 64'd1);
    tick();
    set_in(0, 0, 0, 0);
    cm_valid = 1; cm_rd = 5; cm_prd = 32; cm_prs = 5;
    tick();
    cm_valid = 0;
    set_in(1, 9, 0, 0); #1;
    chk("t3_rdy_cm", 64'(in_ready), 64'd1);
    tick();
    chk("t3_prd", 64'(out_prd.prd), 64'd5);

    // 4: flush restores committed state, with and without same-cycle commit
    do_reset();
    for (int i = 0; i < 3; i++) begin set_in(1, 5 + i, 0, 0); tick(); end
    set_in(0, 0, 0, 0); flush = 1; #1;
    chk("t4_rdy_fl", 64'(in_ready), 64'd0);
    tick(); flush = 0;
    chk("t4_ov", 64'(out_valid), 64'd0);
    chk("t4_fc", 64'(free_cnt), 64'd32);
    set_in(1, 5, 5, 0); tick();
    chk("t4_pr1_id", 64'(out_prd.pr1), 64'd5);
    chk("t4_prd", 64'(out_prd.prd), 64'd32);
    set_in(0, 0, 0, 0); flush = 1;
    cm_valid = 1; cm_rd = 5; cm_prd = 32; cm_prs = 5;
    tick(); flush = 0; cm_valid = 0;
    chk("t4_fc_cm", 64'(free_cnt), 64'd32);
    set_in(1, 6, 5, 0); tick();
    chk("t4_pr1_cm", 64'(out_prd.pr1), 64'd32);
    chk("t4_prd_cm", 64'(out_prd.prd), 64'd5);

    // 5: output stall holds registers, release transfers and accepts same edge
    do_reset();
    set_in(1, 3, 0, 0); tick();
    out_ready = 0; set_in(1, 4, 0, 0);
    held_pc = in_uop.pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_rdy_stall", 64'(in_ready), 64'd0);
      chk("t5_prd_hold", 64'(out_prd.prd), 64'd32);
    end
    out_ready = 1; #1;
    chk("t5_rdy_go", 64'(in_ready), 64'd1);
    tick();
    chk("t5_prd_next", 64'(out_prd.prd), 64'd33);
    chk("t5_pc_next", 64'(out_uop.pc), 64'(held_pc));

    // 6: asynchronous reset mid-stream
    set_in(1, 8, 0, 0); tick();
    chk_en = 0;
    #2 reset = 0;
    #1 chk("t6_ov_async", 64'(out_valid), 64'd0);
    model_reset();
    set_in(0, 0, 0, 0);
    @(posedge clock); #1 reset = 1; chk_en = 1;
    set_in(1, 5, 0, 0); tick();
    chk("t6_prd", 64'(out_prd.prd), 64'd32);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      set_in($urandom_range(0, 3) != 0,
             ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31),
             $urandom_range(0, 31), $urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      cm_valid = 0; cm_rd = '0; cm_prd = '0; cm_prs = '0;
      if (rob.size() > 0 && $urandom_range(0, 2) != 0) begin
        e = rob.pop_front();
        cm_valid = 1; cm_rd = RLEN'(e.rd); cm_prd = PLEN'(e.prd); cm_prs = PLEN'(e.prs);
      end else if ($urandom_range(0, 9) == 0) begin
        cm_valid = 1; cm_rd = '0;
        cm_prd = PLEN'($urandom_range(1, 63)); cm_prs = PLEN'($urandom_range(1, 63));
      end
      tick();
    end
    flush = 0; cm_valid = 0; in_valid = 0;
    @(negedge clock);
    chk_en = 0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
